// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester slice: FSM state encoding and default sizing.
package gcd_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] RESULT  = 2'd3;

  localparam int GCD_WIDTH   = 32;
  localparam int GCD_TIMEOUT = 1024;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Saturating cycle counter that flags when LIMIT cycles have been spent in a wait.
module gcd_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Holds at LAST instead of wrapping so a late done can never look like a fresh start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/gcd_requester.sv
// Initiator side of the GCD go/done handshake: takes operand pairs, drives the unit,
// and hands back the result (or a timeout marker) on a valid/ready output.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_go,
  output logic [WIDTH-1:0] gcd_x,
  output logic [WIDTH-1:0] gcd_y,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_timeout,
  output logic             busy
);

  logic [1:0] state;
  logic [1:0] next_state;
  logic       in_fire;
  logic       out_fire;
  logic       bypass;
  logic       ctr_clear;
  logic       ctr_enable;
  logic       expire;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign bypass     = (in_a == '0) || (in_b == '0);
  assign ctr_clear  = (state != REQ);
  assign ctr_enable = (state == REQ);

  gcd_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout_ctr (
    .clock  (clock),
    .reset  (reset),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expire (expire)
  );

  // Done wins over expiry on the same cycle; stale done outside REQ/RELEASE is ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_fire) next_state = bypass ? RESULT : REQ;
      REQ:     if (gcd_done || expire) next_state = RELEASE;
      RELEASE: if (!gcd_done) next_state = RESULT;
      RESULT:  if (out_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // in_ready is registered from the next state so it never depends combinationally on out_ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      gcd_x       <= '0;
      gcd_y       <= '0;
      out_gcd     <= '0;
      out_timeout <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (in_fire) begin
            if (bypass) begin
              out_gcd     <= in_a | in_b;
              out_timeout <= 1'b0;
            end else begin
              gcd_x <= in_a;
              gcd_y <= in_b;
            end
          end
        end
        REQ: begin
          if (gcd_done) begin
            out_gcd     <= gcd_result;
            out_timeout <= 1'b0;
          end else if (expire) begin
            out_gcd     <= '0;
            out_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gcd_go    = (state == REQ);
  assign out_valid = (state == RESULT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester with a behavioural GCD unit and reference model.
module tb_gcd_requester;

  localparam int W  = 16;
  localparam int TO = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         gcd_go;
  logic [W-1:0] gcd_x;
  logic [W-1:0] gcd_y;
  logic         gcd_done;
  logic [W-1:0] gcd_result;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_gcd;
  logic         out_timeout;
  logic         busy;

  int checks = 0;
  int passed = 0;

  gcd_requester #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .gcd_go      (gcd_go),
    .gcd_x       (gcd_x),
    .gcd_y       (gcd_y),
    .gcd_done    (gcd_done),
    .gcd_result  (gcd_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [W-1:0] t;
    if (a == 0 || b == 0) return a | b;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Behavioural GCD unit: done rises so it is seen on go-cycle unit_delay (0 = never),
  // then stays high for unit_hold cycles after go falls.
  int           unit_delay = 5;
  int           unit_hold  = 1;
  int           go_cnt     = 0;
  int           low_cnt    = 0;
  logic         unit_done  = 1'b0;
  logic [W-1:0] unit_res   = '0;

  assign gcd_done   = unit_done;
  assign gcd_result = unit_res;

  always @(posedge clock) begin
    if (gcd_go) begin
      go_cnt  <= go_cnt + 1;
      low_cnt <= 0;
      if (unit_delay >= 2 && go_cnt + 1 == unit_delay - 1) begin
        unit_done <= 1'b1;
        unit_res  <= ref_gcd(gcd_x, gcd_y);
      end
    end else begin
      go_cnt <= 0;
      if (unit_done) begin
        if (low_cnt + 1 >= unit_hold) unit_done <= 1'b0;
        else low_cnt <= low_cnt + 1;
      end else begin
        low_cnt <= 0;
      end
    end
  end

  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int go_hi, output int rel_cyc, output int lat,
                          output logic [W-1:0] res, output logic tmo,
                          output logic [W-1:0] x_seen, output logic [W-1:0] y_seen,
                          output int early);
    int  n;
    bit  seen_go;
    bit  got;
    go_hi = 0; rel_cyc = 0; lat = 0; res = 'x; tmo = 1'bx;
    x_seen = 'x; y_seen = 'x; early = 0; seen_go = 0; got = 0; n = 0;
    @(negedge clock);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      $display("[TB] FAIL accept_wait: in_ready=%b, expected 1 within 200 cycles", in_ready);
      return;
    end
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      if (out_valid === 1'b1) begin
        got = 1;
        res = out_gcd;
        tmo = out_timeout;
        early = (gcd_done === 1'b1) ? 1 : 0;
      end else begin
        if (gcd_go === 1'b1) begin
          if (!seen_go) begin
            x_seen = gcd_x;
            y_seen = gcd_y;
          end
          seen_go = 1;
          go_hi++;
        end else if (seen_go && busy === 1'b1) begin
          rel_cyc++;
        end
        @(negedge clock);
        lat++;
      end
    end
    if (!got) begin
      checks++;
      $display("[TB] FAIL result_wait: out_valid=%b, expected 1 within 200 cycles", out_valid);
      return;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_a = 16'd5; in_b = 16'd0;
    repeat (3) @(negedge clock);
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy); else passed++;
    checks++; if (gcd_go !== 1'b0) $display("[TB] FAIL reset_go: got %b, expected 0", gcd_go); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); else passed++;
    checks++; if (out_gcd !== 16'd0) $display("[TB] FAIL reset_out_gcd: got %0d, expected 0", out_gcd); else passed++;
    checks++; if (out_timeout !== 1'b0) $display("[TB] FAIL reset_timeout: got %b, expected 0", out_timeout); else passed++;
    checks++; if ({gcd_x, gcd_y} !== 32'd0) $display("[TB] FAIL reset_xy: got %0d/%0d, expected 0/0", gcd_x, gcd_y); else passed++;
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b, expected 1", in_ready); else passed++;
  endtask

  task automatic test_basic();
    int go_hi, rel, lat, early;
    logic [W-1:0] res, xs, ys;
    logic tmo;
    unit_delay = 5; unit_hold = 1;
    run_pair(16'd12, 16'd18, go_hi, rel, lat, res, tmo, xs, ys, early);
    checks++; if (go_hi !== 5) $display("[TB] FAIL basic_go_cycles: got %0d, expected 5", go_hi); else passed++;
    checks++; if (res !== 16'd6) $display("[TB] FAIL basic_result: got %0d, expected 6", res); else passed++;
    checks++; if (tmo !== 1'b0) $display("[TB] FAIL basic_timeout: got %b, expected 0", tmo); else passed++;
    checks++; if (xs !== 16'd12 || ys !== 16'd18) $display("[TB] FAIL basic_xy: got %0d/%0d, expected 12/18", xs, ys); else passed++;
    checks++; if (rel !== unit_hold + 1) $display("[TB] FAIL basic_release: got %0d, expected %0d", rel, unit_hold + 1); else passed++;
  endtask

  task automatic test_bypass();
    logic [W-1:0] as [3];
    logic [W-1:0] bs [3];
    int go_hi, rel, lat, early;
    logic [W-1:0] res, xs, ys;
    logic tmo;
    as[0] = 16'd0; bs[0] = 16'd7;
    as[1] = 16'd0; bs[1] = 16'd0;
    as[2] = W'($urandom_range(1, 60000)); bs[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      run_pair(as[i], bs[i], go_hi, rel, lat, res, tmo, xs, ys, early);
      checks++; if (go_hi !== 0) $display("[TB] FAIL bypass_go[%0d]: got %0d go cycles, expected 0", i, go_hi); else passed++;
      checks++; if (lat !== 1) $display("[TB] FAIL bypass_latency[%0d]: got %0d, expected 1", i, lat); else passed++;
      checks++; if (res !== (as[i] | bs[i]) || tmo !== 1'b0)
        $display("[TB] FAIL bypass_result[%0d]: got %0d tmo=%b, expected %0d tmo=0", i, res, tmo, as[i] | bs[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    int go_hi, rel, lat, early;
    logic [W-1:0] res, xs, ys, ra, rb;
    logic tmo;
    unit_delay = 5; unit_hold = 1;
    out_ready = 1'b0;
    @(negedge clock);
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    in_valid = 1'b1; in_a = 16'd12; in_b = 16'd18;
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    if (out_valid !== 1'b1) begin
      checks++;
      $display("[TB] FAIL bp_result_wait: out_valid=%b, expected 1 within 200 cycles", out_valid);
      out_ready = 1'b1;
      return;
    end
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid[%0d]: got %b, expected 1", i, out_valid); else passed++;
      checks++; if (out_gcd !== 16'd6) $display("[TB] FAIL bp_hold_gcd[%0d]: got %0d, expected 6", i, out_gcd); else passed++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready[%0d]: got %b, expected 0", i, in_ready); else passed++;
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain_valid: got %b, expected 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_drain_in_ready: got %b, expected 1", in_ready); else passed++;
    ra = W'($urandom_range(1, 5000)); rb = W'($urandom_range(1, 5000));
    run_pair(ra, rb, go_hi, rel, lat, res, tmo, xs, ys, early);
    checks++; if (res !== ref_gcd(ra, rb)) $display("[TB] FAIL bp_next_pair: got %0d, expected %0d", res, ref_gcd(ra, rb)); else passed++;
  endtask

  task automatic test_timeout();
    int go_hi, rel, lat, early;
    logic [W-1:0] res, xs, ys;
    logic tmo;
    unit_delay = 0; unit_hold = 1;
    run_pair(16'd35, 16'd21, go_hi, rel, lat, res, tmo, xs, ys, early);
    checks++; if (go_hi !== TO) $display("[TB] FAIL timeout_go_cycles: got %0d, expected %0d", go_hi, TO); else passed++;
    checks++; if (res !== 16'd0) $display("[TB] FAIL timeout_result: got %0d, expected 0", res); else passed++;
    checks++; if (tmo !== 1'b1) $display("[TB] FAIL timeout_flag: got %b, expected 1", tmo); else passed++;
    checks++; if (rel !== 1) $display("[TB] FAIL timeout_release: got %0d, expected 1", rel); else passed++;
    unit_delay = TO;
    run_pair(16'd35, 16'd21, go_hi, rel, lat, res, tmo, xs, ys, early);
    checks++; if (go_hi !== TO) $display("[TB] FAIL edge_go_cycles: got %0d, expected %0d", go_hi, TO); else passed++;
    checks++; if (res !== 16'd7 || tmo !== 1'b0) $display("[TB] FAIL edge_result: got %0d tmo=%b, expected 7 tmo=0", res, tmo); else passed++;
  endtask

  task automatic test_release();
    int go_hi, rel, lat, early;
    logic [W-1:0] res, xs, ys;
    logic tmo;
    unit_delay = 4; unit_hold = 3;
    run_pair(16'd100, 16'd75, go_hi, rel, lat, res, tmo, xs, ys, early);
    checks++; if (rel !== 4) $display("[TB] FAIL release_cycles: got %0d, expected 4", rel); else passed++;
    checks++; if (early !== 0) $display("[TB] FAIL release_early_valid: out_valid with done high, got %0d, expected 0", early); else passed++;
    checks++; if (res !== 16'd25 || tmo !== 1'b0) $display("[TB] FAIL release_result: got %0d tmo=%b, expected 25 tmo=0", res, tmo); else passed++;
    unit_hold = 1;
  endtask

  task automatic test_reset_mid_req();
    int n, gocount;
    int go_hi, rel, lat, early;
    logic [W-1:0] res, xs, ys;
    logic tmo;
    unit_delay = 5; unit_hold = 1;
    @(negedge clock);
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    in_valid = 1'b1; in_a = 16'd20; in_b = 16'd30;
    @(negedge clock);
    in_valid = 1'b0;
    gocount = 0;
    for (int i = 0; i < 20 && gocount < 3; i++) begin
      if (gcd_go === 1'b1) gocount++;
      if (gocount < 3) @(negedge clock);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (gcd_go !== 1'b0) $display("[TB] FAIL midreset_go: got %b, expected 0", gcd_go); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b, expected 0", busy); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midreset_out_valid: got %b, expected 0", out_valid); else passed++;
    reset = 1'b1;
    run_pair(16'd9, 16'd6, go_hi, rel, lat, res, tmo, xs, ys, early);
    checks++; if (res !== 16'd3 || tmo !== 1'b0) $display("[TB] FAIL midreset_next: got %0d tmo=%b, expected 3 tmo=0", res, tmo); else passed++;
  endtask

  task automatic test_random();
    int go_hi, rel, lat, early;
    int exp_go;
    logic [W-1:0] res, xs, ys, a, b, exp_res;
    logic tmo, exp_tmo;
    bit byp;
    for (int i = 0; i < 10; i++) begin
      a = (i % 4 == 3) ? 16'd0 : W'($urandom_range(1, 3000));
      b = W'($urandom_range(1, 3000));
      unit_delay = (i % 3 == 0) ? 0 : int'($urandom_range(2, TO));
      unit_hold  = int'($urandom_range(1, 3));
      byp     = (a == 0);
      exp_tmo = !byp && (unit_delay == 0);
      exp_res = exp_tmo ? '0 : ref_gcd(a, b);
      exp_go  = byp ? 0 : (exp_tmo ? TO : unit_delay);
      run_pair(a, b, go_hi, rel, lat, res, tmo, xs, ys, early);
      checks++; if (res !== exp_res || tmo !== exp_tmo)
        $display("[TB] FAIL rand_result[%0d]: got %0d tmo=%b, expected %0d tmo=%b", i, res, tmo, exp_res, exp_tmo);
      else passed++;
      checks++; if (go_hi !== exp_go) $display("[TB] FAIL rand_go_cycles[%0d]: got %0d, expected %0d", i, go_hi, exp_go); else passed++;
    end
    unit_hold = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_timeout();
    test_release();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
